// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read bus between the sysid checker and the system ID slave.
//   avm_address      word address (0 = system ID, 1 = build timestamp)
//   avm_read         read strobe
//   avm_waitrequest  slave stall
//   avm_readdata     32-bit read data
// master modport: the checker. slave modport: the system ID peripheral.
interface niosii_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// System ID checker: on a start pulse, reads the ID word (address 0) and the
// build timestamp (address 1) from the sysid slave over Avalon-MM. It compares
// both words against the expected values and reports match, pass and timeout.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   start            single-cycle request; ignored while a check is running
//   avm              Avalon-MM read master (address, read, waitrequest, readdata)
//   busy             high from the cycle after start until done
//   done             one-cycle pulse at the end of a check
//   id_value         captured ID word
//   ts_value         captured timestamp word
//   id_match         captured ID word equals EXPECTED_ID
//   ts_match         captured timestamp word equals EXPECTED_TIMESTAMP
//   pass             both words match and no timeout occurred
//   timeout          a read stalled past TIMEOUT_CYCLES
// All status outputs and captured words hold until the next accepted start.
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1490653420,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    niosii_system_sysid_checker_if.master       avm,
    output logic                                busy,
    output logic                                done,
    output logic [31:0]                         id_value,
    output logic [31:0]                         ts_value,
    output logic                                id_match,
    output logic                                ts_match,
    output logic                                pass,
    output logic                                timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID_REQ,
        S_ID_LAT,
        S_TS_REQ,
        S_TS_LAT,
        S_FINISH
    } state_t;

    localparam bit          HAS_LAT     = (READ_LATENCY != 0);
    localparam logic [1:0]  LAT_LAST    = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      r_state;
    logic [1:0]  r_lat;
    logic [15:0] r_wait_cnt;
    logic        r_read;
    logic        r_addr;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_id;
    logic [31:0] r_ts;
    logic        r_id_match;
    logic        r_ts_match;
    logic        r_pass;
    logic        r_timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lat      <= 2'd0;
            r_wait_cnt <= 16'd0;
            r_read     <= 1'b0;
            r_addr     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id       <= 32'd0;
            r_ts       <= 32'd0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ID_REQ;
                        r_read     <= 1'b1;
                        r_addr     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= 16'd0;
                        r_id_match <= 1'b0;
                        r_ts_match <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end

                S_ID_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        r_wait_cnt <= 16'd0;
                        if (!HAS_LAT) begin
                            // Zero-latency slave: data is valid in the accept cycle.
                            r_id    <= avm.avm_readdata;
                            r_addr  <= 1'b1;
                            r_state <= S_TS_REQ;
                        end else begin
                            r_read  <= 1'b0;
                            r_lat   <= 2'd0;
                            r_state <= S_ID_LAT;
                        end
                    end else if (r_wait_cnt == TIMEOUT_LIM) begin
                        // ID never arrived: both match flags stay cleared.
                        r_read    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end

                S_ID_LAT: begin
                    if (r_lat == LAT_LAST) begin
                        r_id    <= avm.avm_readdata;
                        r_read  <= 1'b1;
                        r_addr  <= 1'b1;
                        r_state <= S_TS_REQ;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end

                S_TS_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        r_wait_cnt <= 16'd0;
                        if (!HAS_LAT) begin
                            r_ts       <= avm.avm_readdata;
                            r_id_match <= (r_id == EXPECTED_ID);
                            r_ts_match <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
                            r_pass     <= (r_id == EXPECTED_ID) &&
                                          (avm.avm_readdata == EXPECTED_TIMESTAMP);
                            r_read     <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_FINISH;
                        end else begin
                            r_read  <= 1'b0;
                            r_lat   <= 2'd0;
                            r_state <= S_TS_LAT;
                        end
                    end else if (r_wait_cnt == TIMEOUT_LIM) begin
                        // ID was read this run, so its flag is still meaningful.
                        r_id_match <= (r_id == EXPECTED_ID);
                        r_read     <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end

                S_TS_LAT: begin
                    if (r_lat == LAT_LAST) begin
                        r_ts       <= avm.avm_readdata;
                        r_id_match <= (r_id == EXPECTED_ID);
                        r_ts_match <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
                        r_pass     <= (r_id == EXPECTED_ID) &&
                                      (avm.avm_readdata == EXPECTED_TIMESTAMP);
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end

                // Flags were registered on entry so they are valid alongside done.
                S_FINISH: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avm.avm_read    = r_read;
    assign avm.avm_address = r_addr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign id_value        = r_id;
    assign ts_value        = r_ts;
    assign id_match        = r_id_match;
    assign ts_match        = r_ts_match;
    assign pass            = r_pass;
    assign timeout         = r_timeout;

endmodule
